// File: rtl/rv32i_bus_pkg.sv
// rv32i_bus_pkg: shared APB bridge types and constants.
package rv32i_bus_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_state_e;
    localparam int APB_TIMEOUT_DEFAULT = 15;
    localparam logic [31:0] APB_BASE = 32'h1000_0000;
    localparam logic [31:0] APB_MASK = 32'hFFFF_0000;
endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: APB requester/completer signal bundle.
interface apb_master_bridge_if;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0] PSTRB;
    logic PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    modport master(output PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE, input PRDATA, PREADY, PSLVERR);
    modport slave(input PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a core load/store request into one APB transfer, stalling the core until DONE.
module apb_master_bridge
    import rv32i_bus_pkg::*;
#(
    parameter int APB_TIMEOUT = APB_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bus_re,
    input  logic                bus_we,
    input  logic [31:0]         dAddr,
    input  logic [31:0]         dWdata,
    input  logic [3:0]          wstrb,
    output logic [31:0]         dRdata,
    output logic                stall,
    output logic                bus_err,
    apb_master_bridge_if.master apb
);
    localparam logic [3:0] TO_LAST = 4'(APB_TIMEOUT - 1);
    apb_state_e state;
    logic [3:0] cnt;
    logic req;
    assign req = bus_re | bus_we;
    // Held low during reset so the core is released together with the bus.
    assign stall = req & reset & (state != DONE);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            dRdata      <= '0;
            bus_err     <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            apb.PSTRB   <= '0;
            apb.PWRITE  <= 1'b0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    apb.PADDR  <= dAddr;
                    apb.PWDATA <= dWdata;
                    apb.PSTRB  <= wstrb & {4{bus_we}};
                    apb.PWRITE <= bus_we;
                    apb.PSEL   <= 1'b1;
                    cnt        <= '0;
                    state      <= SETUP;
                end
                SETUP: begin
                    apb.PENABLE <= 1'b1;
                    state       <= ACCESS;
                end
                ACCESS: if (apb.PREADY) begin
                    dRdata      <= apb.PWRITE ? 32'h0 : apb.PRDATA;
                    bus_err     <= bus_err | apb.PSLVERR;
                    apb.PSEL    <= 1'b0;
                    apb.PENABLE <= 1'b0;
                    state       <= DONE;
                end else begin
                    cnt <= cnt + 4'd1;
                    if (cnt == TO_LAST) begin
                        dRdata      <= '0;
                        bus_err     <= 1'b1;
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        state       <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
